// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C master controller and its tick generator.
package i2c_pkg;
   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
   } state_t;

   typedef logic [1:0] phase_t;
   localparam phase_t P0 = 2'd0;
   localparam phase_t P1 = 2'd1;
   localparam phase_t P2 = 2'd2;
   localparam phase_t P3 = 2'd3;
endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick: counts 0..CLK_DIV-1 while enabled, holds while stalled.
module i2c_tick_gen #(
   parameter int CLK_DIV = 32
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic stall_i,
   output logic tick_o
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i)
         cnt_d = '0;
      else if (!stall_i)
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick_o = en_i && !stall_i && (cnt_q == LAST);
endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: 7-bit address, 0..MAX_BYTES payload bytes, write or read,
// byte handshakes on both data sides, NACK reporting.
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int CLK_DIV   = 32,
   parameter int MAX_BYTES = 4,
   parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [I2C_ADDR_W-1:0] addr_i,
   input  logic                  rw_i,
   input  logic [NB_W-1:0]       nbytes_i,
   input  logic [I2C_BYTE_W-1:0] wr_data_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   output logic [I2C_BYTE_W-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ack_err_o,
   output logic                  scl_o,
   inout  wire                   sda_io
);
   localparam logic [NB_W-1:0] MAX_NB = NB_W'(MAX_BYTES);
   localparam logic [NB_W-1:0] ONE_NB = NB_W'(1);

   state_t                  state_q, state_d;
   phase_t                  phase_q;
   logic [2:0]              bit_q;
   logic [I2C_BYTE_W-1:0]   shift_q, rd_data_q;
   logic [NB_W-1:0]         rem_q;
   logic                    rw_q, samp_q, loaded_q, done_q, ack_err_q, rd_valid_q;
   logic                    tick, stall, need_load, accept, bit_end, last_bit, bus_scl, sda_oe;

   assign accept    = start_i && (state_q == IDLE);
   assign bit_end   = tick && (phase_q == P3);
   assign last_bit  = (bit_q == 3'd0);
   assign bus_scl   = (phase_q == P1) || (phase_q == P2);
   // Write byte is fetched at the first cycle of bit 7; without data the bus waits with SCL low.
   assign need_load = (state_q == WR_BYTE) && (phase_q == P0) && (bit_q == 3'd7) && !loaded_q;
   assign stall     = need_load && !wr_valid_i;

   i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (busy_o),
      .stall_i (stall),
      .tick_o  (tick)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = START;
         START:    if (bit_end) state_d = ADDR;
         ADDR:     if (bit_end && last_bit) state_d = ADDR_ACK;
         ADDR_ACK: if (bit_end)
                      state_d = (samp_q || rem_q == '0) ? STOP : (rw_q ? RD_BYTE : WR_BYTE);
         WR_BYTE:  if (bit_end && last_bit) state_d = WR_ACK;
         WR_ACK:   if (bit_end) state_d = (samp_q || rem_q == ONE_NB) ? STOP : WR_BYTE;
         RD_BYTE:  if (bit_end && last_bit) state_d = RD_ACK;
         RD_ACK:   if (bit_end) state_d = (rem_q == ONE_NB) ? STOP : RD_BYTE;
         STOP:     if (bit_end) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      scl_o      = 1'b1;
      sda_oe     = 1'b0;
      wr_ready_o = need_load && wr_valid_i;
      case (state_q)
         START: begin
            scl_o  = (phase_q != P3);
            sda_oe = (phase_q != P0);
         end
         ADDR, WR_BYTE: begin
            scl_o  = bus_scl;
            sda_oe = ~shift_q[7];
         end
         ADDR_ACK, WR_ACK, RD_BYTE: scl_o = bus_scl;
         RD_ACK: begin
            scl_o  = bus_scl;
            sda_oe = (rem_q > ONE_NB);
         end
         STOP: begin
            scl_o  = (phase_q != P0);
            sda_oe = (phase_q == P0) || (phase_q == P1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         phase_q    <= P0;
         bit_q      <= 3'd7;
         shift_q    <= '0;
         rw_q       <= 1'b0;
         rem_q      <= '0;
         samp_q     <= 1'b1;
         loaded_q   <= 1'b0;
         done_q     <= 1'b0;
         ack_err_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         if (accept) begin
            phase_q   <= P0;
            bit_q     <= 3'd7;
            shift_q   <= {addr_i, rw_i};
            rw_q      <= rw_i;
            rem_q     <= (nbytes_i > MAX_NB) ? MAX_NB : nbytes_i;
            ack_err_q <= 1'b0;
            loaded_q  <= 1'b0;
         end
         if (need_load && wr_valid_i) begin
            shift_q  <= wr_data_i;
            loaded_q <= 1'b1;
         end
         if (tick) begin
            phase_q  <= phase_q + 2'd1;
            loaded_q <= 1'b0;
            case (phase_q)
               P2: begin
                  samp_q <= sda_io;
                  if (state_q == RD_BYTE) begin
                     shift_q <= {shift_q[6:0], sda_io};
                     if (last_bit) begin
                        rd_data_q  <= {shift_q[6:0], sda_io};
                        rd_valid_q <= 1'b1;
                     end
                  end
               end
               P3: begin
                  bit_q <= (state_q inside {ADDR, WR_BYTE, RD_BYTE}) ? bit_q - 3'd1 : 3'd7;
                  if (state_q inside {ADDR, WR_BYTE})
                     shift_q <= {shift_q[6:0], 1'b0};
                  if ((state_q == ADDR_ACK || state_q == WR_ACK) && samp_q)
                     ack_err_q <= 1'b1;
                  if ((state_q == WR_ACK && !samp_q) || state_q == RD_ACK)
                     rem_q <= rem_q - ONE_NB;
                  if (state_q == STOP)
                     done_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign sda_io     = sda_oe ? 1'b0 : 1'bz;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign ack_err_o  = ack_err_q;
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural I2C slave on the bus.
module tb_i2c_master_ctrl;
   localparam int CLK_DIV   = 4;
   localparam int MAX_BYTES = 4;
   localparam int NB_W      = 3;

   logic            clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0, wr_valid = 1'b1;
   logic [6:0]      addr = '0;
   logic [NB_W-1:0] nbytes = '0;
   logic [7:0]      wr_data, rd_data;
   logic            wr_ready, rd_valid, busy, done, ack_err, scl;
   wire             sda_w;

   int total = 0, bad = 0;
   int wrr_cnt = 0, done_cnt = 0, coinc = 0, sda_hi_chg = 0, scl_bad = 0;
   int ign_at = -1, widx = 0;
   logic wadv = 1'b0;

   logic [7:0] wvec [4];
   logic [7:0] slv_rdv [4];
   logic [7:0] bus_q [$];
   logic [7:0] rd_q [$];
   logic       ack_q [$];

   int         bi = 0, fi = 0;
   logic [7:0] sh = '0, rb = '0;
   logic       slv_act = 1'b0, slv_drv = 1'b0, slv_nack = 1'b0, slv_rd = 1'b0;

   always #5 clk = ~clk;

   i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .addr_i(addr), .rw_i(rw),
      .nbytes_i(nbytes), .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
      .rd_data_o(rd_data), .rd_valid_o(rd_valid), .busy_o(busy), .done_o(done),
      .ack_err_o(ack_err), .scl_o(scl), .sda_io(sda_w)
   );

   pullup (sda_w);
   assign sda_w   = slv_drv ? 1'b0 : 1'bz;
   assign wr_data = wvec[widx[1:0]];

   // Slave: START/STOP detection, bit capture on SCL rise, drive on SCL fall.
   always @(negedge sda_w) if (scl === 1'b1) begin slv_act = 1'b1; bi = 0; fi = 0; slv_drv = 1'b0; end
   always @(posedge sda_w) if (scl === 1'b1) slv_act = 1'b0;
   always @(sda_w) if (scl === 1'b1) sda_hi_chg++;

   always @(posedge scl) if (slv_act) begin
      if (bi < 8) begin
         sh = {sh[6:0], sda_w};
         if (bi == 7) begin
            bus_q.push_back(sh);
            if (fi == 0) slv_rd = sh[0];
         end
         bi++;
      end else begin
         ack_q.push_back(sda_w);
         if (sda_w) slv_act = 1'b0;
         bi = 0;
         fi++;
      end
   end

   always @(negedge scl) begin
      slv_drv = 1'b0;
      if (slv_act) begin
         if (fi == 0)
            slv_drv = (bi == 8) && !slv_nack;
         else if (slv_rd) begin
            rb = slv_rdv[(fi - 1) & 3];
            slv_drv = (bi < 8) && (fi <= 4) && !rb[7 - bi];
         end else
            slv_drv = (bi == 8);
      end
   end

   always @(negedge clk) begin
      if (wr_ready) begin wrr_cnt++; wadv = 1'b1; end
      if (rd_valid) rd_q.push_back(rd_data);
      if (done) done_cnt++;
      if (rd_valid && done) coinc++;
   end

   always @(posedge clk) begin
      #1;
      if (wadv) begin
         wadv = 1'b0;
         if (widx < 3) widx++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input logic [6:0] a, input logic r, input logic [NB_W-1:0] nb,
                      input int stall_at, input int exp_cyc, input string tag);
      int n;
      bus_q.delete(); ack_q.delete(); rd_q.delete();
      wrr_cnt = 0; done_cnt = 0; coinc = 0; widx = 0; sda_hi_chg = 0; scl_bad = 0;
      addr = a; rw = r; nbytes = nb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      chk({tag, "_busy1"}, busy, 1);
      chk({tag, "_ackerr_clr"}, ack_err, 0);
      while (!done && n < 3000) begin
         if (stall_at > 0 && n >= stall_at && n < stall_at + 100 && scl !== 1'b0) scl_bad++;
         if (n == stall_at) wr_valid = 1'b0;
         if (n == stall_at + 100) wr_valid = 1'b1;
         if (n == ign_at) begin start = 1'b1; addr = 7'h7F; nbytes = 3'd3; end
         else start = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_done_cyc"}, n, exp_cyc);
      chk({tag, "_busy_end"}, busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   initial begin
      int nacks;
      wvec[0] = 8'h34; wvec[1] = 8'h56; wvec[2] = 8'h78; wvec[3] = 8'h9A;
      slv_rdv[0] = 8'hA5; slv_rdv[1] = 8'h3C; slv_rdv[2] = 8'hFF; slv_rdv[3] = 8'hFF;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ackerr", ack_err, 0);
      chk("rst_wrready", wr_ready, 0);
      chk("rst_rdvalid", rd_valid, 0);
      chk("rst_rddata", rd_data, 0);
      chk("rst_scl", scl, 1);
      chk("rst_sda", sda_w, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      // 3-byte write
      run(7'h1A, 1'b0, 3'd3, -1, 609, "wr3");
      chk("wr3_nbus", bus_q.size(), 4);
      chk("wr3_b0", bus_q[0], 8'h34);
      chk("wr3_b1", bus_q[1], 8'h34);
      chk("wr3_b2", bus_q[2], 8'h56);
      chk("wr3_b3", bus_q[3], 8'h78);
      nacks = 0;
      foreach (ack_q[i]) nacks += int'(ack_q[i]);
      chk("wr3_nack_bits", ack_q.size() * 16 + nacks, 4 * 16);
      chk("wr3_wrready", wrr_cnt, 3);
      chk("wr3_ackerr", ack_err, 0);
      chk("wr3_sda_hi_chg", sda_hi_chg, 2);

      // 2-byte read
      run(7'h50, 1'b1, 3'd2, -1, 465, "rd2");
      chk("rd2_nrd", rd_q.size(), 2);
      chk("rd2_d0", rd_q[0], 8'hA5);
      chk("rd2_d1", rd_q[1], 8'h3C);
      chk("rd2_addr", bus_q[0], 8'hA1);
      chk("rd2_nack_q", ack_q.size(), 3);
      chk("rd2_mack1", ack_q[1], 0);
      chk("rd2_mnack2", ack_q[2], 1);
      chk("rd2_wrready", wrr_cnt, 0);
      chk("rd2_coinc", coinc, 0);
      chk("rd2_ackerr", ack_err, 0);

      // Address NACK
      slv_nack = 1'b1;
      run(7'h1A, 1'b0, 3'd2, -1, 177, "nak");
      slv_nack = 1'b0;
      chk("nak_ackerr", ack_err, 1);
      chk("nak_wrready", wrr_cnt, 0);
      chk("nak_nbus", bus_q.size(), 1);
      repeat (20) @(posedge clk);
      #1;
      chk("nak_ackerr_hold", ack_err, 1);

      // Write with a 100-cycle stall at the second byte
      run(7'h1A, 1'b0, 3'd3, 305, 709, "stl");
      chk("stl_scl_low", scl_bad, 0);
      chk("stl_sda_hi_chg", sda_hi_chg, 2);
      chk("stl_wrready", wrr_cnt, 3);
      chk("stl_b2", bus_q[2], 8'h56);
      chk("stl_b3", bus_q[3], 8'h78);

      // nbytes above MAX_BYTES clamps to MAX_BYTES
      run(7'h1A, 1'b0, 3'd7, -1, 753, "clp");
      chk("clp_nbus", bus_q.size(), 5);
      chk("clp_b4", bus_q[4], 8'h9A);
      chk("clp_wrready", wrr_cnt, 4);

      // nbytes=0 probe with an ignored start while busy
      ign_at = 50;
      run(7'h1A, 1'b0, 3'd0, -1, 177, "prb");
      ign_at = -1;
      chk("prb_nbus", bus_q.size(), 1);
      chk("prb_addr", bus_q[0], 8'h34);
      repeat (100) @(posedge clk);
      #1;
      chk("prb_idle_busy", busy, 0);
      chk("prb_idle_done", done_cnt, 1);

      // Reset in the middle of the address byte
      done_cnt = 0;
      addr = 7'h1A; rw = 1'b0; nbytes = 3'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (33) @(posedge clk);
      #1;
      chk("mrst_scl_pre", scl, 0);
      chk("mrst_sda_pre", sda_w, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mrst_scl", scl, 1);
      chk("mrst_sda", sda_w, 1);
      chk("mrst_busy", busy, 0);
      rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("mrst_nodone", done_cnt, 0);
      chk("mrst_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Parametrised I2C master controller. Successor to the fixed-format 3-byte write-only controller used for codec configuration.
- Generates SCL from a programmable divider and drives open-drain SDA.
- Runs 7-bit-address transactions of 0..MAX_BYTES payload bytes, in either write or read mode.
- Streams write data in and read data out through byte handshakes. Reports NACK errors. Sits between the codec/sensor config sequencers and the board I2C pins.

Parameters:
- CLK_DIV, 32, system clocks per quarter SCL period (SCL period = 4*CLK_DIV clocks); legal range ≥2.
- MAX_BYTES, 4, maximum payload bytes per transaction; legal range ≥1.
- NB_W, $clog2(MAX_BYTES+1), width of the byte-count port (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request; sampled only when busy=0
- addr  in  7  target address; latched on accepted start
- rw  in  1  0=write, 1=read; latched on accepted start
- nbytes  in  NB_W  payload byte count; latched on accepted start; values >MAX_BYTES clamp to MAX_BYTES
- wr_data  in  8  next write byte
- wr_valid  in  1  wr_data is valid
- wr_ready  out  1  one-cycle pulse: byte consumed this cycle
- rd_data  out  8  received byte
- rd_valid  out  1  one-cycle pulse: rd_data is valid
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction
- ack_err  out  1  NACK seen in last transaction; held until next accepted start
- scl  out  1  I2C clock (push-pull, single master)
- sda  inout  1  open-drain: drives 0 or 'z', never 1

Behaviour:
- Reset values: busy=0, done=0, ack_err=0, wr_ready=0, rd_valid=0, rd_data=0, scl=1, sda=z, state=IDLE, divider=0.
- Reset mid-transaction aborts immediately to these values. No STOP is generated.
- Quarter tick: the divider counts 0..CLK_DIV-1 only while busy and emits a 1-cycle tick at CLK_DIV-1. Each bus bit is 4 ticks, phases P0..P3.
- Normal bit: P0 SCL low, set SDA. P1 SCL high. P2 sample SDA (SCL high). P3 SCL low.
- Accepted start: at cycle 0 (start=1, busy=0), latch inputs. busy=1 from cycle 1. ack_err cleared.
- State START: P0 SCL=1, SDA=z. P1 SDA=0. P2 hold. P3 SCL=0.
- State ADDR: 8 bits, {addr, rw}, MSB first.
- State ADDR_ACK: SDA released; sample at P2. On NACK: ack_err=1, go to STOP. On ACK: if nbytes=0 go to STOP, else go to WR_BYTE or RD_BYTE.
- State WR_BYTE: at P0 of bit 7, load shift register if wr_valid=1 and pulse wr_ready in the same cycle. If wr_valid=0, freeze the divider with SCL low (stall) until wr_valid=1.
- State WR_ACK: NACK sets ack_err=1 and goes to STOP, even if bytes remain. ACK decrements the remaining count. Remaining=0 goes to STOP, else WR_BYTE.
- State RD_BYTE: SDA released, sample 8 bits MSB first at P2. rd_valid pulses with rd_data at P3 of bit 0. There is no backpressure on the read side.
- State RD_ACK: master drives SDA=0 (ACK) when bytes remain. Master releases SDA (NACK) on the last byte, then goes to STOP.
- State STOP: P0 SCL low, SDA=0. P1 SCL=1. P2 SDA=z. P3: busy=0, done=1 for 1 cycle, state to IDLE.
- Latency without stalls: done is asserted at cycle 1 + (2 + 9*(1+n))*4*CLK_DIV after the accepted start, where n is the number of bytes actually transferred.
- start while busy=1 is ignored; no queueing.
- wr_valid outside WR_BYTE load points is ignored.
- done and rd_valid never coincide.

Decomposition:
- Shared package i2c_pkg holds:
  - state_t enum: IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP.
  - phase_t, 2-bit.
  - I2C_ADDR_W=7 and I2C_BYTE_W=8.
- One sub-module: i2c_tick_gen (parameter CLK_DIV; inputs clk, rst, en, stall; output tick).

Test Plan:
- Write 3 bytes: CLK_DIV=4, addr=0x1A, rw=0, nbytes=3, slave ACKs, wr_data 0x34,0x56,0x78 always valid -> bus shows 0x34 (address byte), 0x34, 0x56, 0x78; three wr_ready pulses; done at cycle 609; ack_err=0.
- Read 2 bytes: addr=0x50, rw=1, nbytes=2, slave returns 0xA5, 0x3C -> rd_valid twice with 0xA5 then 0x3C; master ACKs byte 1 and NACKs byte 2; done at cycle 1+(2+27)*16=465.
- Address NACK: slave leaves SDA high after the address byte -> ack_err=1, STOP follows immediately, no wr_ready pulses, done at cycle 1+11*16=177.
- Write stall: wr_valid held 0 for 100 cycles at byte 2 -> SCL stays low for the whole stall, no SDA change while SCL is high, done delayed by exactly 100 cycles.
- Edge cases: nbytes=0 probe -> done at cycle 1+11*16=177. start pulsed while busy -> ignored. rst asserted mid-ADDR -> next cycle scl=1, sda=z, busy=0, no done pulse.
